// File: rtl/motion_pkg.sv
// Shared types for the motion pipeline output stage.
// A stream beat carries the pixel plus frame-boundary markers through the output FIFO.
package motion_pkg;

    typedef logic [31:0] pixel_t;

    typedef struct packed {
        logic   last;
        logic   sof;
        pixel_t data;
    } stream_beat_t;

    localparam int PIPE_FLUSH_CYCLES = 3;

endpackage

// File: rtl/motion_stream_out_if.sv
// AXI4-Stream bundle with tlast = end of frame and tuser = start of frame.
interface motion_stream_out_if #(
    parameter int DATA_WIDTH = 32
) ();

    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );

endinterface

// File: rtl/motion_stream_out_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is presented on rd_data while not empty.
// rd_data reads as zero when empty so downstream fields are clean after reset.
module sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap at DEPTH without extra logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_en && !rd_en) begin
                count <= count + CW'(1);
            end else if (rd_en && !wr_en) begin
                count <= count - CW'(1);
            end
        end
    end

    assign rd_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/motion_stream_out.sv
// Output stage of the motion pipeline: buffers the highlighted-pixel stream and emits it
// as AXI4-Stream with frame markers, almost_full backpressure, overflow and frame counting.
module motion_stream_out
    import motion_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AF_MARGIN  = PIPE_FLUSH_CYCLES + 1,
    parameter int FCNT_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    input  logic                  pixel_valid,
    input  logic                  pixel_last,
    motion_stream_out_if.master   m_axis,
    output logic                  almost_full,
    output logic                  overflow,
    input  logic                  clear_overflow,
    output logic [FCNT_BITS-1:0]  frame_count
);

    localparam int                CW       = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]     AF_LEVEL = CW'(DEPTH - AF_MARGIN);

    stream_beat_t  wr_beat;
    stream_beat_t  rd_beat;
    logic [CW-1:0] count;
    logic [CW-1:0] next_count;
    logic          sof_pending;
    logic          rd;
    logic          wr_en;
    logic          drop;

    assign rd    = m_axis.tvalid && m_axis.tready;
    assign wr_en = pixel_valid && ((count != FULL_CNT) || rd);
    assign drop  = pixel_valid && (count == FULL_CNT) && !rd;

    always_comb begin
        wr_beat      = '0;
        wr_beat.last = pixel_last;
        wr_beat.sof  = sof_pending;
        wr_beat.data = pixel_in;
    end

    sync_fifo #(
        .WIDTH ($bits(stream_beat_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_beat),
        .rd_en   (rd),
        .rd_data (rd_beat),
        .count   (count)
    );

    // tvalid comes only from FIFO occupancy, never from tready.
    assign m_axis.tvalid = (count != '0);
    assign m_axis.tdata  = rd_beat.data;
    assign m_axis.tlast  = rd_beat.last;
    assign m_axis.tuser  = rd_beat.sof;

    always_comb begin
        next_count = count;
        if (wr_en && !rd) begin
            next_count = count + CW'(1);
        end else if (rd && !wr_en) begin
            next_count = count - CW'(1);
        end
    end

    // A dropped last pixel still closes the frame so the next one starts with tuser set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sof_pending <= 1'b1;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            frame_count <= '0;
        end else begin
            if (pixel_valid) begin
                sof_pending <= pixel_last;
            end
            almost_full <= (next_count >= AF_LEVEL);
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
            if (rd && m_axis.tlast) begin
                frame_count <= frame_count + FCNT_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_motion_stream_out.sv
// Bench for motion_stream_out: directed frame scenarios followed by random traffic,
// all compared cycle by cycle against a queue-based model of the output stream.
module tb_motion_stream_out;
    import motion_pkg::*;

    localparam int DEPTH = 16;
    localparam int AF_AT = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pixel_in = '0;
    logic        pixel_valid = 1'b0;
    logic        pixel_last = 1'b0;
    logic        almost_full;
    logic        overflow;
    logic        clear_overflow = 1'b0;
    logic [15:0] frame_count;

    motion_stream_out_if #(.DATA_WIDTH(32)) axis ();

    motion_stream_out dut (
        .clk            (clk),
        .rst            (rst),
        .pixel_in       (pixel_in),
        .pixel_valid    (pixel_valid),
        .pixel_last     (pixel_last),
        .m_axis         (axis),
        .almost_full    (almost_full),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .frame_count    (frame_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    stream_beat_t q[$];
    logic         m_sof = 1'b1;
    logic         m_ovf = 1'b0;
    logic [15:0]  m_fc  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        logic exp_v;
        exp_v = (q.size() != 0);
        check("tvalid", 32'(axis.tvalid), 32'(exp_v));
        if (exp_v) begin
            check("tdata", axis.tdata, q[0].data);
            check("tlast", 32'(axis.tlast), 32'(q[0].last));
            check("tuser", 32'(axis.tuser), 32'(q[0].sof));
        end
        check("almost_full", 32'(almost_full), 32'(q.size() >= AF_AT));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("frame_count", 32'(frame_count), 32'(m_fc));
    endtask

    // Called at a falling edge: check, drive, let the rising edge happen, advance the model.
    task automatic step(input logic pv, input logic pl, input logic [31:0] d,
                        input logic rdy, input logic clr);
        logic rd, wr, drop;
        compare_outputs();
        pixel_valid    = pv;
        pixel_last     = pl;
        pixel_in       = d;
        axis.tready    = rdy;
        clear_overflow = clr;
        rd   = (q.size() != 0) && rdy;
        wr   = pv && ((q.size() < DEPTH) || rd);
        drop = pv && (q.size() == DEPTH) && !rd;
        @(posedge clk);
        if (rd) begin
            if (q[0].last) m_fc++;
            void'(q.pop_front());
        end
        if (wr) q.push_back(stream_beat_t'{last: pl, sof: m_sof, data: d});
        if (pv) m_sof = pl;
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        @(negedge clk);
    endtask

    task automatic reset_dut();
        pixel_valid    = 1'b0;
        pixel_last     = 1'b0;
        pixel_in       = '0;
        clear_overflow = 1'b0;
        axis.tready    = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_tvalid", 32'(axis.tvalid), 0);
        check("rst_tdata", axis.tdata, 0);
        check("rst_tlast", 32'(axis.tlast), 0);
        check("rst_tuser", 32'(axis.tuser), 0);
        check("rst_almost_full", 32'(almost_full), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_frame_count", 32'(frame_count), 0);
        q.delete();
        m_sof = 1'b1;
        m_ovf = 1'b0;
        m_fc  = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_pix();
        logic [31:0] p;
        p = $urandom();
        p[7:0] = 8'h00;
        return p;
    endfunction

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, rdy, 1'b0);
    endtask

    initial begin
        logic [15:0] fc0;
        int          rdy_pct;
        axis.tready = 1'b0;
        @(negedge clk);
        reset_dut();

        // one 4-pixel frame, sink always ready
        for (int i = 0; i < 4; i++) step(1'b1, i == 3, rand_pix(), 1'b1, 1'b0);
        idle(3, 1'b1);
        check("t1_frame_count", 32'(frame_count), 1);
        check("t1_overflow", 32'(overflow), 0);

        // stalled sink: fill, drop the 17th, then drain
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 1'b0, rand_pix(), 1'b0, 1'b0);
            if (i == 11) check("t2_af_after_12", 32'(almost_full), 1);
            if (i == 10) check("t2_af_before_12", 32'(almost_full), 0);
        end
        check("t2_overflow", 32'(overflow), 1);
        idle(18, 1'b1);

        // full FIFO with read and write in the same cycle: no drop
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, i == 15, rand_pix(), 1'b0, 1'b0);
        step(1'b1, 1'b0, rand_pix(), 1'b1, 1'b0);
        check("t3_overflow", 32'(overflow), 0);
        check("t3_still_full", 32'(q.size() == DEPTH && axis.tvalid && almost_full), 1);
        idle(18, 1'b1);

        // two back-to-back 3-pixel frames
        fc0 = m_fc;
        for (int i = 0; i < 6; i++) step(1'b1, (i % 3) == 2, rand_pix(), 1'b1, 1'b0);
        idle(3, 1'b1);
        check("t4_frames", 32'(frame_count), 32'(fc0 + 16'd2));

        // drop and clear_overflow in the same cycle: set wins
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, rand_pix(), 1'b0, 1'b0);
        step(1'b1, 1'b0, rand_pix(), 1'b0, 1'b1);
        check("t5_set_wins", 32'(overflow), 1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("t5_cleared", 32'(overflow), 0);
        idle(18, 1'b1);

        // reset in the middle of a frame with 5 buffered entries
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, rand_pix(), 1'b0, 1'b0);
        reset_dut();
        step(1'b1, 1'b0, rand_pix(), 1'b0, 1'b0);
        check("t6_tuser", 32'(axis.tuser), 1);
        check("t6_tvalid", 32'(axis.tvalid), 1);
        idle(2, 1'b1);

        // random traffic with shifting sink throughput
        rdy_pct = 50;
        for (int i = 0; i < 2000; i++) begin
            if (i % 200 == 0) rdy_pct = $urandom_range(100, 10);
            step($urandom_range(99) < 70, $urandom_range(4) == 0, rand_pix(),
                 $urandom_range(99) < rdy_pct, $urandom_range(29) == 0);
        end
        idle(20, 1'b1);
        compare_outputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
